// File: rtl/audio_seq_pkg.sv
// Shared types, constants and note-pitch helpers for the melody sequencer.
// Optional build macro: AUDIO_SEQ_HARMONY_EN (see audio_seq_ctrl).
package audio_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int NOTE_W   = 5;
  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 3;
  localparam int HALF_W   = 24;

  localparam logic [NOTE_W-1:0] NOTE_REST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_END  = 5'd31;
  localparam logic [VOL_W-1:0]  VOL_RST   = 3'd4;
  localparam logic [VOL_W-1:0]  VOL_MAX   = 3'd7;

  // Codes 1..24 are pitched notes; everything else is silent.
  function automatic logic is_tone(input logic [NOTE_W-1:0] code);
    return (code >= 5'd1) && (code <= 5'd24);
  endfunction

  // Equal-tempered C4..B5 in millihertz; 0 for silent codes.
  function automatic logic [31:0] note_mhz(input logic [NOTE_W-1:0] code);
    logic [31:0] f;
    case (code)
      5'd1:  f = 32'd261626;  5'd2:  f = 32'd277183;  5'd3:  f = 32'd293665;
      5'd4:  f = 32'd311127;  5'd5:  f = 32'd329628;  5'd6:  f = 32'd349228;
      5'd7:  f = 32'd369994;  5'd8:  f = 32'd391995;  5'd9:  f = 32'd415305;
      5'd10: f = 32'd440000;  5'd11: f = 32'd466164;  5'd12: f = 32'd493883;
      5'd13: f = 32'd523251;  5'd14: f = 32'd554365;  5'd15: f = 32'd587330;
      5'd16: f = 32'd622254;  5'd17: f = 32'd659255;  5'd18: f = 32'd698456;
      5'd19: f = 32'd739989;  5'd20: f = 32'd783991;  5'd21: f = 32'd830609;
      5'd22: f = 32'd880000;  5'd23: f = 32'd932328;  5'd24: f = 32'd987767;
      default: f = 32'd0;
    endcase
    return f;
  endfunction

  // Rounded clk_hz / (2 * f_note) in clock cycles. Only ever evaluated on
  // constants, so the divider folds away at elaboration.
  function automatic logic [HALF_W-1:0] half_period(input logic [NOTE_W-1:0] code,
                                                    input int unsigned clk_hz);
    logic [63:0] f;
    logic [63:0] num;
    logic [63:0] q;
    f = {32'd0, note_mhz(code)};
    if (f == 64'd0) return '0;
    num = {32'd0, clk_hz} * 64'd1000 + f;
    q   = num / (f << 1);
    return q[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/audio_seq_ctrl_melody_rom.sv
// Fixed melody table: 5-bit address to 5-bit note code, purely combinational.
module melody_rom
  import audio_seq_pkg::*;
(
  input  logic [NOTE_W-1:0] addr_i,
  output logic [NOTE_W-1:0] code_o
);

  // Table lookup; unlisted addresses are rests.
  always_comb begin
    code_o = NOTE_REST;
    case (addr_i)
      5'd0:    code_o = 5'd10;     // A4
      5'd1:    code_o = NOTE_REST;
      5'd2:    code_o = 5'd1;      // C4
      5'd3:    code_o = NOTE_END;
      default: code_o = NOTE_REST;
    endcase
  end

endmodule

// File: rtl/audio_seq_ctrl.sv
// Melody sequencer: steps the note table once per beat and renders a square
// wave per note onto the 16-bit left/right samples of the speaker serializer.
// Build macro AUDIO_SEQ_HARMONY_EN: right channel plays one octave below left
// with its own tone counter; without it the right channel mirrors the left.
module audio_seq_ctrl
  import audio_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned BEAT_DIV = 25_000_000,
  parameter int unsigned NOTE_NUM = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                vol_up,
  input  logic                vol_down,
  output logic [SAMPLE_W-1:0] audio_left,
  output logic [SAMPLE_W-1:0] audio_right,
  output logic                busy,
  output logic [NOTE_W-1:0]   note_addr,
  output logic [VOL_W-1:0]    volume,
  output logic [1:0]          dbg_state
);

  localparam int BEAT_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
  localparam logic [NOTE_W-1:0] ADDR_LAST = NOTE_W'(NOTE_NUM - 1);

  state_t              state_q, state_d;
  logic [NOTE_W-1:0]   addr_q, addr_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [HALF_W-1:0]   tone_q, tone_d;
  logic                phase_q, phase_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic                clr_tone;

  logic [NOTE_W-1:0]   code, next_code;
  logic [HALF_W-1:0]   half;
  logic [HALF_W-1:0]   half_tbl [32];
  logic [SAMPLE_W-1:0] amp;
  logic                sound;

`ifdef AUDIO_SEQ_HARMONY_EN
  logic [HALF_W:0]     tone2_q, tone2_d;
  logic                phase2_q, phase2_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic [HALF_W:0]     half2;
  assign half2 = {half, 1'b0};
`endif

  melody_rom u_rom_cur  (.addr_i(addr_q),         .code_o(code));
  melody_rom u_rom_next (.addr_i(addr_q + 5'd1),  .code_o(next_code));

  for (genvar g = 0; g < 32; g++) begin : g_half
    assign half_tbl[g] = half_period(NOTE_W'(g), CLK_HZ);
  end
  assign half = half_tbl[code];

  // Transport FSM, beat stepping and tone counters.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    beat_d   = beat_q;
    tone_d   = tone_q;
    phase_d  = phase_q;
    clr_tone = 1'b0;
`ifdef AUDIO_SEQ_HARMONY_EN
    tone2_d  = tone2_q;
    phase2_d = phase2_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d  = S_PLAY;
          addr_d   = '0;
          beat_d   = '0;
          clr_tone = 1'b1;
        end
      end
      S_PLAY: begin
        // The cycle that carries a pause pulse still counts as a PLAY cycle.
        if (is_tone(code)) begin
          if (tone_q == half - HALF_W'(1)) begin
            tone_d  = '0;
            phase_d = ~phase_q;
          end else begin
            tone_d = tone_q + HALF_W'(1);
          end
`ifdef AUDIO_SEQ_HARMONY_EN
          if (tone2_q == half2 - (HALF_W+1)'(1)) begin
            tone2_d  = '0;
            phase2_d = ~phase2_q;
          end else begin
            tone2_d = tone2_q + (HALF_W+1)'(1);
          end
`endif
        end
        if (beat_q == BEAT_LAST) begin
          beat_d   = '0;
          clr_tone = 1'b1;
          if (addr_q == ADDR_LAST || next_code == NOTE_END) begin
            addr_d = '0;
            if (!loop_en) state_d = S_IDLE;
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
        // A finished song wins over a pause request on the same edge.
        if (play && state_d == S_PLAY) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (play) state_d = S_PLAY;
      end
      default: state_d = S_IDLE;
    endcase
    if (stop) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      beat_d   = '0;
      clr_tone = 1'b1;
    end
    if (clr_tone) begin
      tone_d  = '0;
      phase_d = 1'b0;
`ifdef AUDIO_SEQ_HARMONY_EN
      tone2_d  = '0;
      phase2_d = 1'b0;
`endif
    end
  end

  // Saturating volume; simultaneous up/down cancel.
  always_comb begin
    vol_d = vol_q;
    if (vol_up && !vol_down && vol_q != VOL_MAX) vol_d = vol_q + 3'd1;
    if (vol_down && !vol_up && vol_q != 3'd0)    vol_d = vol_q - 3'd1;
  end

  // Sample values from the current registered state, landing one cycle later.
  assign amp   = {1'b0, vol_q, 12'h000};
  assign sound = (state_q == S_PLAY) && is_tone(code);
  always_comb begin
    left_d = '0;
    if (sound) left_d = phase_q ? amp : (~amp + 16'd1);
`ifdef AUDIO_SEQ_HARMONY_EN
    right_d = '0;
    if (sound) right_d = phase2_q ? amp : (~amp + 16'd1);
`endif
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      vol_q    <= VOL_RST;
      beat_q   <= '0;
      tone_q   <= '0;
      phase_q  <= 1'b0;
      left_q   <= '0;
`ifdef AUDIO_SEQ_HARMONY_EN
      tone2_q  <= '0;
      phase2_q <= 1'b0;
      right_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      vol_q    <= vol_d;
      beat_q   <= beat_d;
      tone_q   <= tone_d;
      phase_q  <= phase_d;
      left_q   <= left_d;
`ifdef AUDIO_SEQ_HARMONY_EN
      tone2_q  <= tone2_d;
      phase2_q <= phase2_d;
      right_q  <= right_d;
`endif
    end
  end

  assign audio_left = left_q;
`ifdef AUDIO_SEQ_HARMONY_EN
  assign audio_right = right_q;
`else
  assign audio_right = left_q;
`endif
  assign busy      = (state_q != S_IDLE);
  assign note_addr = addr_q;
  assign volume    = vol_q;
  assign dbg_state = state_q;

endmodule
